// File: rtl/reg_alu.sv
// Eight-entry 8-bit register file with two combinational read ports and a
// 2-input ALU whose result can be written back through the single write port.
module reg_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       wr,
  input  logic [1:0] op,
  input  logic [2:0] rd_addr_a,
  input  logic [2:0] rd_addr_b,
  input  logic [2:0] wr_addr,
  input  logic [7:0] d_in,
  output logic [7:0] d_out_a,
  output logic [7:0] d_out_b,
  output logic       cout
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [DW-1:0] r_regs [DEPTH];
  logic [DW:0]   w_wide;
  logic [DW-1:0] w_alu_y;
  logic          w_alu_c;
  logic [DW-1:0] w_wdata;

  assign d_out_a = r_regs[rd_addr_a];
  assign d_out_b = r_regs[rd_addr_b];

  // ALU on the two read-port values; subtract is a + ~b + 1 so cout means a >= b.
  always_comb begin
    w_wide  = '0;
    w_alu_y = '0;
    w_alu_c = 1'b0;
    case (op)
      OP_ADD: begin
        w_wide  = {1'b0, d_out_a} + {1'b0, d_out_b};
        w_alu_y = w_wide[DW-1:0];
        w_alu_c = w_wide[DW];
      end
      OP_SUB: begin
        w_wide  = {1'b0, d_out_a} + {1'b0, ~d_out_b} + (DW+1)'(1);
        w_alu_y = w_wide[DW-1:0];
        w_alu_c = w_wide[DW];
      end
      OP_AND:  w_alu_y = d_out_a & d_out_b;
      OP_OR:   w_alu_y = d_out_a | d_out_b;
      default: w_alu_y = '0;
    endcase
  end

  assign cout    = w_alu_c;
  assign w_wdata = sel ? w_alu_y : d_in;

  // Reset wins over write; reads see the new value only after the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (wr) begin
      r_regs[wr_addr] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_reg_alu.sv
// Directed self-checking bench for reg_alu with hand-computed expected values.
module tb_reg_alu;

  logic       clk = 1'b0;
  logic       reset, sel, wr;
  logic [1:0] op;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] d_in;
  logic [7:0] d_out_a, d_out_b;
  logic       cout;

  int n_checks = 0;
  int n_errors = 0;

  reg_alu dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .wr        (wr),
    .op        (op),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    wr = 1'b0;
    #1;
  endtask

  task automatic wr_data(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    sel = 1'b0; wr = 1'b1; wr_addr = addr; d_in = data;
    commit();
  endtask

  // Sets up an ALU operation at the falling edge; caller checks, then commits if we=1.
  task automatic alu_setup(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] addr, input logic we);
    @(negedge clk);
    sel = 1'b1; wr = we; op = o; wr_addr = addr;
    rd(a, b);
  endtask

  logic [7:0] exp_regs [8];

  initial begin
    reset = 1'b1; sel = 1'b0; wr = 1'b0; op = 2'b00;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; d_in = '0;

    // Reset over two edges, then every address reads zero
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      check("reset_a", 16'(d_out_a), 16'h00);
      check("reset_b", 16'(d_out_b), 16'h00);
    end

    // External writes
    wr_data(3'd3, 8'd6);
    wr_data(3'd7, 8'd4);
    wr_data(3'd5, 8'd2);
    wr_data(3'd1, 8'd5);
    rd(3'd3, 3'd7);
    check("wr_r3", 16'(d_out_a), 16'h06);
    check("wr_r7", 16'(d_out_b), 16'h04);
    rd(3'd1, 3'd5);
    check("wr_r1", 16'(d_out_a), 16'h05);
    check("wr_r5", 16'(d_out_b), 16'h02);

    // ADD 5+2 -> r3
    alu_setup(2'b00, 3'd1, 3'd5, 3'd3, 1'b1);
    check("add_cout", 16'(cout), 16'h0);
    commit();
    rd(3'd3, 3'd3);
    check("add_r3", 16'(d_out_a), 16'h07);
    check("same_addr_b", 16'(d_out_b), 16'h07);

    // SUB 2-4 -> r7 = FE, borrow so cout=0
    alu_setup(2'b01, 3'd5, 3'd7, 3'd7, 1'b1);
    check("sub_borrow_cout", 16'(cout), 16'h0);
    commit();
    rd(3'd7, 3'd7);
    check("sub_r7", 16'(d_out_a), 16'hFE);

    // SUB FE-2 = FC, cout=1; written to r0 which is an ordinary register
    alu_setup(2'b01, 3'd7, 3'd5, 3'd0, 1'b1);
    check("sub_nb_cout", 16'(cout), 16'h1);
    commit();
    rd(3'd0, 3'd0);
    check("sub_r0", 16'(d_out_a), 16'hFC);

    // AND 7 & FE -> r5 = 6
    alu_setup(2'b10, 3'd3, 3'd7, 3'd5, 1'b1);
    commit();
    rd(3'd5, 3'd5);
    check("and_r5", 16'(d_out_a), 16'h06);

    // OR 5 | 6 -> r1 = 7
    alu_setup(2'b11, 3'd1, 3'd5, 3'd1, 1'b1);
    check("or_cout", 16'(cout), 16'h0);
    commit();
    rd(3'd1, 3'd1);
    check("or_r1", 16'(d_out_a), 16'h07);

    // No write-through: old value before the edge, new value after
    @(negedge clk);
    sel = 1'b0; wr = 1'b1; wr_addr = 3'd6; d_in = 8'h5A;
    rd(3'd6, 3'd6);
    check("pre_edge_r6", 16'(d_out_a), 16'h00);
    commit();
    check("post_edge_r6", 16'(d_out_a), 16'h5A);

    // cout tracks op/operands with wr=0: FE,7 -> ADD carries, AND/OR never do
    alu_setup(2'b00, 3'd7, 3'd3, 3'd0, 1'b0);
    check("add_carry_nowr", 16'(cout), 16'h1);
    op = 2'b11; #1;
    check("or_cout_zero", 16'(cout), 16'h0);
    op = 2'b10; #1;
    check("and_cout_zero", 16'(cout), 16'h0);

    // FF + 01 with read-modify-write into r2
    wr_data(3'd2, 8'hFF);
    wr_data(3'd4, 8'h01);
    alu_setup(2'b00, 3'd2, 3'd4, 3'd2, 1'b1);
    check("ff_plus1_cout", 16'(cout), 16'h1);
    commit();
    rd(3'd2, 3'd4);
    check("ff_plus1_y", 16'(d_out_a), 16'h00);
    check("rmw_b_kept", 16'(d_out_b), 16'h01);

    // SUB with equal operands sets cout; 0-1 borrows
    alu_setup(2'b01, 3'd4, 3'd4, 3'd0, 1'b0);
    check("sub_eq_cout", 16'(cout), 16'h1);
    rd(3'd2, 3'd4);
    check("sub_0m1_cout", 16'(cout), 16'h0);

    // wr=0 with changing data, select and addresses leaves state alone
    exp_regs = '{8'hFC, 8'h07, 8'h00, 8'h07, 8'h01, 8'h06, 8'h5A, 8'hFE};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr = 1'b0; sel = 1'(i); op = 2'(i); wr_addr = 3'(i + 2);
      d_in = 8'($urandom);
      rd_addr_a = 3'($urandom); rd_addr_b = 3'($urandom);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(i));
      check("hold_reg", 16'(d_out_a), 16'(exp_regs[i]));
    end

    // Reset beats a simultaneous write
    @(negedge clk);
    reset = 1'b1; wr = 1'b1; sel = 1'b0; wr_addr = 3'd3; d_in = 8'hAA;
    @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0;
    rd(3'd3, 3'd7);
    check("rst_wr_r3", 16'(d_out_a), 16'h00);
    check("rst_wr_r7", 16'(d_out_b), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
